hazard_fwd_unit: RTL and testbench

Parametrised hazard-detection and forwarding controller for the 5-stage pipelined core (IF/ID/EX/MEM/WB). It keeps its own shadow pipeline of destination and operand register tags for the EX, MEM and WB stages. From that it generates:
- PC and IF/ID stall signals, plus the ID/EX bubble.
- Flush controls when a taken redirect arrives from EX/MEM.
- Operand-forwarding selects for the instruction in EX.
- Saturating stall and flush event counters.

It replaces the single-purpose load-use stall counter logic and scales to any register-file size, link register and counter width.

---
 rtl/hazard_fwd_unit.sv | 127 ++++++++++++
 tb/tb_hazard_fwd_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Load-use hazard detection, redirect flush and EX operand forwarding
// driven by a shadow pipeline of register tags for EX, MEM and WB.
module hazard_fwd_unit #(
  parameter int REG_AW   = 4,
  parameter int LINK_REG = 15,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_use,
  input  logic              id_rs2_use,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic              id_is_link,
  input  logic              flush,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic [CNT_W-1:0]  cnt_flush
);

  typedef logic [REG_AW-1:0] tag_t;

  typedef struct packed {
    logic valid;
    logic wen;
    tag_t rd;
    logic is_load;
    tag_t rs1;
    logic rs1_use;
    tag_t rs2;
    logic rs2_use;
  } shadow_t;

  shadow_t ex_q, mem_q, wb_q, ex_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
  logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;
  logic hz;
  tag_t rd_eff;

  function automatic logic wr(input shadow_t s, input tag_t r);
    return s.valid & s.wen & (s.rd == r) & (r != '0);
  endfunction

  assign rd_eff = id_is_link ? tag_t'(LINK_REG) : id_rd;

  assign hz = id_valid & ex_q.valid & ex_q.is_load & ex_q.wen
            & (ex_q.rd != '0)
            & ((id_rs1_use & (ex_q.rd == id_rs1))
            |  (id_rs2_use & (ex_q.rd == id_rs2)));

  // A redirect squashes the stall: the stalled consumer is dead anyway.
  assign stall_pc    = hz & ~flush;
  assign stall_ifid  = hz & ~flush;
  assign bubble_idex = hz | flush;
  assign flush_ifid  = flush;

  always_comb begin
    ex_d = '0;
    if (id_valid & ~hz & ~flush) begin
      ex_d.valid   = 1'b1;
      ex_d.wen     = id_wen;
      ex_d.rd      = rd_eff;
      ex_d.is_load = id_is_load;
      ex_d.rs1     = id_rs1;
      ex_d.rs1_use = id_rs1_use;
      ex_d.rs2     = id_rs2;
      ex_d.rs2_use = id_rs2_use;
    end
  end

  // MEM is the younger writer, so it is tested first.
  always_comb begin
    fwd_a = 2'd0;
    priority case (1'b1)
      ex_q.rs1_use & wr(mem_q, ex_q.rs1) & ~mem_q.is_load: fwd_a = 2'd1;
      ex_q.rs1_use & wr(wb_q, ex_q.rs1):                   fwd_a = 2'd2;
      default:                                              fwd_a = 2'd0;
    endcase
  end

  always_comb begin
    fwd_b = 2'd0;
    priority case (1'b1)
      ex_q.rs2_use & wr(mem_q, ex_q.rs2) & ~mem_q.is_load: fwd_b = 2'd1;
      ex_q.rs2_use & wr(wb_q, ex_q.rs2):                   fwd_b = 2'd2;
      default:                                              fwd_b = 2'd0;
    endcase
  end

  always_comb begin
    cnt_stall_d = cnt_stall_q;
    cnt_flush_d = cnt_flush_q;
    if (stall_pc && (cnt_stall_q != '1))
      cnt_stall_d = cnt_stall_q + CNT_W'(1);
    if (flush && (cnt_flush_q != '1))
      cnt_flush_d = cnt_flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      cnt_stall_q <= '0;
      cnt_flush_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      cnt_stall_q <= cnt_stall_d;
      cnt_flush_q <= cnt_flush_d;
    end
  end

  assign cnt_stall = cnt_stall_q;
  assign cnt_flush = cnt_flush_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: default instance plus a
// 2-bit-counter instance sharing the same stimulus.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_use, id_rs2_use;
  logic       id_wen, id_is_load, id_is_link;
  logic       flush;

  logic        stall_pc, stall_ifid, bubble_idex, flush_ifid;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] cnt_stall, cnt_flush;

  logic        s_stall_pc, s_stall_ifid, s_bubble_idex, s_flush_ifid;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [1:0]  s_cnt_stall, s_cnt_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
    .id_is_link(id_is_link), .flush(flush),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .bubble_idex(bubble_idex), .flush_ifid(flush_ifid),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
  );

  hazard_fwd_unit #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
    .id_is_link(id_is_link), .flush(flush),
    .stall_pc(s_stall_pc), .stall_ifid(s_stall_ifid),
    .bubble_idex(s_bubble_idex), .flush_ifid(s_flush_ifid),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .cnt_stall(s_cnt_stall), .cnt_flush(s_cnt_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input logic v, input logic [3:0] rs1, input logic u1,
                     input logic [3:0] rs2, input logic u2,
                     input logic [3:0] rd, input logic w,
                     input logic ld, input logic lk);
    id_valid   = v;
    id_rs1     = rs1;
    id_rs1_use = u1;
    id_rs2     = rs2;
    id_rs2_use = u2;
    id_rd      = rd;
    id_wen     = w;
    id_is_load = ld;
    id_is_link = lk;
    #1;
  endtask

  task automatic nop();
    drv(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    nop();
    tick();
    tick();
    chk("rst_stall_pc", stall_pc, 0);
    chk("rst_bubble", bubble_idex, 0);
    chk("rst_flush_ifid", flush_ifid, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    chk("rst_cnt_stall", cnt_stall, 0);
    chk("rst_cnt_flush", cnt_flush, 0);
    rst = 1'b0;

    // ALU chain: ADD R3 ; SUB R4,R3,R3
    drv(1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0);
    tick();
    drv(1, 4'd3, 1, 4'd3, 1, 4'd4, 1, 0, 0);
    chk("alu_no_stall", stall_pc, 0);
    tick();
    nop();
    chk("alu_fwd_a_mem", fwd_a, 1);
    chk("alu_fwd_b_mem", fwd_b, 1);
    tick();

    // ADD R3 ; ADD R7 ; SUB R4,R3,R3
    drv(1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0);
    tick();
    drv(1, 4'd1, 1, 4'd2, 1, 4'd7, 1, 0, 0);
    tick();
    drv(1, 4'd3, 1, 4'd3, 1, 4'd4, 1, 0, 0);
    tick();
    nop();
    chk("gap_fwd_a_wb", fwd_a, 2);
    chk("gap_fwd_b_wb", fwd_b, 2);
    tick();

    // Load-use: LW R5 ; ADD R6,R5,R1
    drv(1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 1, 0);
    tick();
    drv(1, 4'd5, 1, 4'd1, 1, 4'd6, 1, 0, 0);
    chk("lu_stall_pc", stall_pc, 1);
    chk("lu_stall_ifid", stall_ifid, 1);
    chk("lu_bubble", bubble_idex, 1);
    tick();
    chk("lu_stall_released", stall_pc, 0);
    chk("lu_bubble_released", bubble_idex, 0);
    chk("lu_cnt_stall", cnt_stall, 1);
    tick();
    nop();
    chk("lu_fwd_a_wb", fwd_a, 2);
    chk("lu_fwd_b_rf", fwd_b, 0);
    tick();

    // Double writer: MEM beats WB
    drv(1, 4'd1, 1, 4'd1, 1, 4'd2, 1, 0, 0);
    tick();
    drv(1, 4'd1, 1, 4'd1, 1, 4'd2, 1, 0, 0);
    tick();
    drv(1, 4'd2, 1, 4'd2, 1, 4'd8, 1, 0, 0);
    tick();
    nop();
    chk("dbl_fwd_a", fwd_a, 1);
    chk("dbl_fwd_b", fwd_b, 1);
    tick();

    // R0 as load destination and ALU destination
    drv(1, 4'd1, 1, 4'd0, 0, 4'd0, 1, 1, 0);
    tick();
    drv(1, 4'd0, 1, 4'd0, 1, 4'd9, 1, 0, 0);
    chk("r0_load_no_stall", stall_pc, 0);
    tick();
    nop();
    chk("r0_load_fwd_a", fwd_a, 0);
    drv(1, 4'd1, 1, 4'd1, 1, 4'd0, 1, 0, 0);
    tick();
    drv(1, 4'd0, 1, 4'd0, 1, 4'd9, 1, 0, 0);
    tick();
    nop();
    chk("r0_alu_fwd_a", fwd_a, 0);
    chk("r0_alu_fwd_b", fwd_b, 0);
    tick();

    // JAL with rd field 3 writes R15
    drv(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 0, 1);
    tick();
    drv(1, 4'd15, 1, 4'd3, 1, 4'd9, 1, 0, 0);
    tick();
    nop();
    chk("link_fwd_a", fwd_a, 1);
    chk("link_fwd_b", fwd_b, 0);
    tick();

    // Flush in the same cycle as a load-use hazard
    drv(1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 1, 0);
    tick();
    drv(1, 4'd5, 1, 4'd0, 0, 4'd7, 1, 1, 0);
    flush = 1'b1;
    #1;
    chk("fl_stall_pc", stall_pc, 0);
    chk("fl_stall_ifid", stall_ifid, 0);
    chk("fl_flush_ifid", flush_ifid, 1);
    chk("fl_bubble", bubble_idex, 1);
    tick();
    flush = 1'b0;
    drv(1, 4'd7, 1, 4'd5, 1, 4'd9, 1, 0, 0);
    chk("fl_ex_invalid", stall_pc, 0);
    chk("fl_cnt_flush", cnt_flush, 1);
    chk("fl_cnt_stall", cnt_stall, 1);
    tick();
    nop();
    chk("fl_fwd_a", fwd_a, 0);
    chk("fl_wb_retires", fwd_b, 2);
    tick();

    // Back-to-back loads: one stall only
    drv(1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 1, 0);
    tick();
    drv(1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 1, 0);
    chk("b2b_no_stall_ld", stall_pc, 0);
    tick();
    drv(1, 4'd5, 1, 4'd0, 0, 4'd6, 1, 0, 0);
    chk("b2b_stall", stall_pc, 1);
    tick();
    chk("b2b_single_stall", stall_pc, 0);
    tick();
    nop();
    chk("b2b_fwd_a", fwd_a, 2);
    tick();

    // Five more stall events saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      drv(1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 1, 0);
      tick();
      drv(1, 4'd5, 1, 4'd0, 0, 4'd6, 1, 0, 0);
      tick();
    end
    nop();
    chk("sat_cnt_stall", s_cnt_stall, 3);
    chk("sat_cnt_flush", s_cnt_flush, 1);
    chk("wide_cnt_stall", cnt_stall, 7);

    // Reset in the middle of a stall
    drv(1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 1, 0);
    tick();
    drv(1, 4'd5, 1, 4'd0, 0, 4'd6, 1, 0, 0);
    chk("pre_rst_stall", stall_pc, 1);
    rst = 1'b1;
    tick();
    chk("post_rst_stall", stall_pc, 0);
    chk("post_rst_bubble", bubble_idex, 0);
    chk("post_rst_fwd_a", fwd_a, 0);
    chk("post_rst_cnt_stall", cnt_stall, 0);
    chk("post_rst_cnt_flush", cnt_flush, 0);
    chk("post_rst_sat_cnt", s_cnt_stall, 0);
    rst = 1'b0;
    nop();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
